// File: rtl/tx_bit_timer.sv
// Slave-transmit bit sequencer: drives a byte MSB-first on SDA during SCL low
// phases, releases SDA for the ACK slot and reports the master's ACK/NACK.
module tx_bit_timer #(
  parameter int NUM_DATA_BITS = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rising_edge_found,
  input  logic                                   falling_edge_found,
  input  logic                                   start_found,
  input  logic                                   stop_found,
  input  logic                                   load_byte,
  input  logic [NUM_DATA_BITS-1:0]               tx_data,
  input  logic                                   sda_in,
  output logic                                   sda_out,
  output logic                                   tx_active,
  output logic                                   ack_received,
  output logic                                   nack_received,
  output logic                                   next_byte_req,
  output logic [$clog2(NUM_DATA_BITS+1)-1:0]     bit_count
);

  localparam int CW = $clog2(NUM_DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DATA_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK_WAIT, ACK_HOLD} state_t;

  state_t                   state_q, state_d;
  logic [NUM_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     acked_q, acked_d;
  logic                     sda_q, sda_d;
  logic                     active_q, active_d;
  logic                     ack_q, ack_d;
  logic                     nack_q, nack_d;
  logic                     req_q, req_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acked_d  = acked_q;
    sda_d    = sda_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    nack_d   = 1'b0;
    req_d    = 1'b0;
    if (start_found || stop_found) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_d = 1'b1;
          if (load_byte && !falling_edge_found && !rising_edge_found) begin
            shreg_d = tx_data;
            sda_d   = tx_data[NUM_DATA_BITS-1];
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (falling_edge_found) begin
            if (cnt_q == FULL) begin
              sda_d   = 1'b1;
              state_d = ACK_WAIT;
            end else begin
              // Rotate rather than zero-fill: vacated LSBs are never driven.
              shreg_d = {shreg_q[NUM_DATA_BITS-2:0], shreg_q[NUM_DATA_BITS-1]};
              sda_d   = shreg_q[NUM_DATA_BITS-2];
            end
          end else if (rising_edge_found && cnt_q != FULL) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ACK_WAIT: begin
          if (rising_edge_found && !falling_edge_found) begin
            acked_d = ~sda_in;
            ack_d   = ~sda_in;
            nack_d  = sda_in;
            state_d = ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          if (falling_edge_found) begin
            req_d   = acked_q;
            if (acked_q) cnt_d = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acked_q  <= 1'b0;
      sda_q    <= 1'b1;
      active_q <= 1'b0;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acked_q  <= acked_d;
      sda_q    <= sda_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      nack_q   <= nack_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sda_out       = sda_q;
  assign tx_active     = active_q;
  assign ack_received  = ack_q;
  assign nack_received = nack_q;
  assign next_byte_req = req_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_tx_bit_timer.sv
// Bench for tx_bit_timer: an 8-bit and a 4-bit instance share one stimulus bus.
module tb_tx_bit_timer;

  logic       clk = 1'b0;
  logic       rst, rise, fall, start, stop, load, sda_in;
  logic [7:0] tx_data;

  logic       sda8, act8, ack8, nack8, req8;
  logic [3:0] cnt8;
  logic       sda4, act4, ack4, nack4, req4;
  logic [2:0] cnt4;

  int n_checks = 0;
  int n_errors = 0;
  logic sb_q[$];

  localparam int P_RISE = 0, P_FALL = 1, P_LOAD = 2, P_START = 3, P_STOP = 4, P_RST = 5;

  always #5 clk = ~clk;

  tx_bit_timer #(.NUM_DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .load_byte(load), .tx_data(tx_data),
    .sda_in(sda_in), .sda_out(sda8), .tx_active(act8), .ack_received(ack8),
    .nack_received(nack8), .next_byte_req(req8), .bit_count(cnt8));

  tx_bit_timer #(.NUM_DATA_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .load_byte(load), .tx_data(tx_data[3:0]),
    .sda_in(sda_in), .sda_out(sda4), .tx_active(act4), .ack_received(ack4),
    .nack_received(nack4), .next_byte_req(req4), .bit_count(cnt4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One-cycle pulse driven at a negedge; on return the DUT has registered it.
  task automatic pulse(input int k);
    case (k)
      P_RISE:  rise  = 1'b1;
      P_FALL:  fall  = 1'b1;
      P_LOAD:  load  = 1'b1;
      P_START: start = 1'b1;
      P_STOP:  stop  = 1'b1;
      default: rst   = 1'b1;
    endcase
    @(negedge clk);
    {rise, fall, load, start, stop, rst} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic mnack, input bit inject);
    logic e;
    for (int i = 7; i >= 0; i--) sb_q.push_back(d[i]);
    tx_data = d;
    pulse(P_LOAD);
    check("load_sda", sda8, d[7]);
    check("load_active", act8, 1);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      pulse(P_RISE);
      e = sb_q.pop_front();
      check("bit_sda", sda8, e);
      check("bit_count", cnt8, i + 1);
      idle(1);
      if (inject && i == 3) begin
        tx_data = 8'h00;
        pulse(P_LOAD);
        check("ignored_load", sda8, e);
      end
      pulse(P_FALL);
    end
    check("released", sda8, 1);
    check("ackwait_active", act8, 1);
    sda_in = mnack;
    idle(1);
    pulse(P_RISE);
    check("ack_pulse", ack8, !mnack);
    check("nack_pulse", nack8, mnack);
    idle(1);
    check("ack_one_cycle", {ack8, nack8}, 0);
    sda_in = 1'b1;
    pulse(P_FALL);
    check("next_req", req8, !mnack);
    check("idle_active", act8, 0);
    check("idle_sda", sda8, 1);
    if (!mnack) check("count_cleared", cnt8, 0);
    idle(1);
    check("req_one_cycle", req8, 0);
  endtask

  initial begin
    {rise, fall, load, start, stop} = '0;
    rst = 1'b1; sda_in = 1'b1; tx_data = 8'h00;
    idle(3);
    rst = 1'b0;
    check("rst_sda", sda8, 1);
    check("rst_flags", {act8, ack8, nack8, req8}, 0);
    check("rst_count", cnt8, 0);
    idle(2);

    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h3C, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);

    tx_data = 8'h00;
    pulse(P_LOAD);
    repeat (2) begin pulse(P_RISE); idle(1); pulse(P_FALL); idle(1); end
    pulse(P_RISE);
    check("pre_stop_count", cnt8, 3);
    pulse(P_STOP);
    check("stop_sda", sda8, 1);
    check("stop_active", act8, 0);
    check("stop_count", cnt8, 0);
    pulse(P_RISE); idle(1); pulse(P_FALL);
    check("post_stop_count", cnt8, 0);
    check("post_stop_sda", {sda8, act8}, 2'b10);
    idle(2);

    tx_data = 8'h00;
    pulse(P_LOAD);
    repeat (4) begin pulse(P_RISE); idle(1); pulse(P_FALL); idle(1); end
    pulse(P_RISE);
    check("mid_count", cnt8, 5);
    check("mid_sda", sda8, 0);
    pulse(P_RST);
    check("midrst_sda", sda8, 1);
    check("midrst_flags", {act8, ack8, nack8, req8}, 0);
    check("midrst_count", cnt8, 0);
    idle(1);
    send_byte(8'h80, 1'b0, 0);

    send_byte(8'hFF, 1'b0, 1);

    pulse(P_RST);
    idle(1);
    tx_data = 8'h09;
    for (int i = 3; i >= 0; i--) sb_q.push_back(tx_data[i]);
    pulse(P_LOAD);
    check("n4_load_sda", sda4, 1);
    for (int i = 0; i < 4; i++) begin
      logic e;
      idle(1);
      pulse(P_RISE);
      e = sb_q.pop_front();
      check("n4_bit_sda", sda4, e);
      check("n4_count", cnt4, i + 1);
      if (i == 3) begin
        repeat (2) begin idle(1); pulse(P_RISE); end
        check("n4_saturate", cnt4, 4);
        check("n4_hold_sda", sda4, e);
        check("n4_still_shift", {act4, ack4, nack4}, 3'b100);
      end
      idle(1);
      pulse(P_FALL);
    end
    check("n4_released", sda4, 1);
    sda_in = 1'b0;
    idle(1);
    pulse(P_RISE);
    check("n4_ack", {ack4, nack4}, 2'b10);
    sda_in = 1'b1;
    idle(1);
    pulse(P_FALL);
    check("n4_req", req4, 1);
    check("n4_idle", {act4, cnt4}, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
